// File: rtl/priv_trap_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : priv_trap_arbiter_if
// Description : Pipeline/CSR-facing signal bundle of the trap arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface priv_trap_arbiter_if #(
    parameter int XLEN    = 32,
    parameter int NUM_INT = 12,
    parameter int NUM_EXC = 16
);
    logic [NUM_INT-1:0] int_src;
    logic [NUM_INT-1:0] int_clr;
    logic [NUM_INT-1:0] int_en;
    logic               glob_ie;
    logic [NUM_EXC-1:0] exc_src;
    logic [XLEN-1:0]    exc_tval;
    logic [XLEN-1:0]    epc;
    logic               pipe_clear;
    logic               mret;
    logic [XLEN-1:0]    mtvec_base;
    logic               mtvec_mode;
    logic [XLEN-1:0]    mepc_in;

    logic [NUM_INT-1:0] pending;
    logic               intr;
    logic               busy;
    logic               inject;
    logic               restore;
    logic [XLEN-1:0]    next_mcause;
    logic [XLEN-1:0]    next_mepc;
    logic [XLEN-1:0]    next_mtval;
    logic               insert_pc;
    logic [XLEN-1:0]    priv_pc;

    modport master (
        output int_src, int_clr, int_en, glob_ie, exc_src, exc_tval, epc,
               pipe_clear, mret, mtvec_base, mtvec_mode, mepc_in,
        input  pending, intr, busy, inject, restore, next_mcause, next_mepc,
               next_mtval, insert_pc, priv_pc
    );

    modport slave (
        input  int_src, int_clr, int_en, glob_ie, exc_src, exc_tval, epc,
               pipe_clear, mret, mtvec_base, mtvec_mode, mepc_in,
        output pending, intr, busy, inject, restore, next_mcause, next_mepc,
               next_mtval, insert_pc, priv_pc
    );
endinterface
`default_nettype wire

// File: rtl/priv_trap_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : priv_trap_arbiter
// Description : Interrupt/exception prioritiser and trap FSM. Optional NMI
//               input is enabled by defining PRIV_TRAP_NMI_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module priv_trap_arbiter #(
    parameter int              XLEN       = 32,
    parameter int              NUM_INT    = 12,
    parameter int              NUM_EXC    = 16,
    parameter logic [XLEN-1:0] NMI_VECTOR = '0
) (
    input  wire logic          CLK,
    input  wire logic          RST,
`ifdef PRIV_TRAP_NMI_EN
    input  wire logic          nmi,
`endif
    priv_trap_arbiter_if.slave bus
);
    localparam int IW = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
    localparam int EW = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_COMMIT = 2'd2,
        S_RET    = 2'd3
    } state_t;

    state_t             r_state;
    logic [NUM_INT-1:0] r_pending;
    logic               r_intr, r_busy, r_inject, r_restore, r_insert;
    logic [XLEN-1:0]    r_mcause, r_mepc, r_mtval, r_priv_pc;
    logic               r_cap_irq, r_cap_nmi;

    logic [NUM_INT-1:0] w_int_elig;
    logic               w_int_any, w_exc_any, w_nmi_pend;
    logic [IW-1:0]      w_int_idx;
    logic [EW-1:0]      w_exc_idx;
    logic               w_load, w_new_irq, w_new_nmi;
    logic [XLEN-1:0]    w_new_mcause, w_new_tval;
    logic [XLEN-1:0]    w_cap_mcause, w_cap_epc, w_cap_tval;
    logic               w_cap_irq, w_cap_nmi;
    logic [XLEN-1:0]    w_base, w_trap_pc;
    logic               w_unused;

    assign w_unused = ^bus.mtvec_base[1:0];

`ifdef PRIV_TRAP_NMI_EN
    logic r_nmi_q, r_nmi_pend;
    assign w_nmi_pend = r_nmi_pend;

    // Set on the rising edge; cleared only when the NMI itself commits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_nmi_q    <= 1'b0;
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_q    <= nmi;
            r_nmi_pend <= (r_nmi_pend & ~((r_state == S_COMMIT) & r_cap_nmi))
                        | (nmi & ~r_nmi_q);
        end
    end
`else
    assign w_nmi_pend = 1'b0;
`endif

    always_comb begin
        w_int_elig = r_pending & bus.int_en & {NUM_INT{bus.glob_ie}};
        w_int_any  = |w_int_elig;
        w_int_idx  = '0;
        for (int i = 0; i < NUM_INT; i++)
            if (w_int_elig[i]) w_int_idx = IW'(i);
        w_exc_any = |bus.exc_src;
        w_exc_idx = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--)
            if (bus.exc_src[i]) w_exc_idx = EW'(i);
    end

    // New capture: IDLE takes the best source, WAIT only upgrades an interrupt.
    always_comb begin
        w_load       = 1'b0;
        w_new_irq    = 1'b0;
        w_new_nmi    = 1'b0;
        w_new_mcause = '0;
        w_new_tval   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_nmi_pend) begin
                    w_load       = 1'b1;
                    w_new_irq    = 1'b1;
                    w_new_nmi    = 1'b1;
                    w_new_mcause = {1'b1, {(XLEN-1){1'b0}}};
                end else if (w_exc_any) begin
                    w_load       = 1'b1;
                    w_new_mcause = XLEN'(w_exc_idx);
                    w_new_tval   = bus.exc_tval;
                end else if (w_int_any) begin
                    w_load       = 1'b1;
                    w_new_irq    = 1'b1;
                    w_new_mcause = {1'b1, (XLEN-1)'(w_int_idx)};
                end
            end
            S_WAIT: begin
                if (w_nmi_pend && r_cap_irq && !r_cap_nmi) begin
                    w_load       = 1'b1;
                    w_new_irq    = 1'b1;
                    w_new_nmi    = 1'b1;
                    w_new_mcause = {1'b1, {(XLEN-1){1'b0}}};
                end else if (w_exc_any && r_cap_irq && !r_cap_nmi) begin
                    w_load       = 1'b1;
                    w_new_mcause = XLEN'(w_exc_idx);
                    w_new_tval   = bus.exc_tval;
                end
            end
            default: ;
        endcase
    end

    assign w_cap_mcause = w_load ? w_new_mcause : r_mcause;
    assign w_cap_epc    = w_load ? bus.epc      : r_mepc;
    assign w_cap_tval   = w_load ? w_new_tval   : r_mtval;
    assign w_cap_irq    = w_load ? w_new_irq    : r_cap_irq;
    assign w_cap_nmi    = w_load ? w_new_nmi    : r_cap_nmi;

    // Shifting the whole mcause left by 2 drops the interrupt flag for free.
    assign w_base    = {bus.mtvec_base[XLEN-1:2], 2'b00};
    assign w_trap_pc = w_cap_nmi ? NMI_VECTOR :
                       (w_cap_irq && bus.mtvec_mode) ? (w_base + {w_cap_mcause[XLEN-3:0], 2'b00}) :
                       w_base;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_intr    <= 1'b0;
            r_busy    <= 1'b0;
            r_inject  <= 1'b0;
            r_restore <= 1'b0;
            r_insert  <= 1'b0;
            r_mcause  <= '0;
            r_mepc    <= '0;
            r_mtval   <= '0;
            r_priv_pc <= '0;
            r_cap_irq <= 1'b0;
            r_cap_nmi <= 1'b0;
        end else begin
            r_pending <= (r_pending | bus.int_src) & ~bus.int_clr;
            r_mcause  <= w_cap_mcause;
            r_mepc    <= w_cap_epc;
            r_mtval   <= w_cap_tval;
            r_cap_irq <= w_cap_irq;
            r_cap_nmi <= w_cap_nmi;
            r_intr    <= 1'b0;
            r_inject  <= 1'b0;
            r_restore <= 1'b0;
            r_insert  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state <= S_WAIT;
                        r_intr  <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (bus.mret) begin
                        r_state   <= S_RET;
                        r_restore <= 1'b1;
                        r_insert  <= 1'b1;
                        r_priv_pc <= bus.mepc_in;
                        r_busy    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.pipe_clear) begin
                        r_state   <= S_COMMIT;
                        r_inject  <= 1'b1;
                        r_insert  <= 1'b1;
                        r_priv_pc <= w_trap_pc;
                    end else begin
                        r_intr <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pending     = r_pending;
    assign bus.intr        = r_intr;
    assign bus.busy        = r_busy;
    assign bus.inject      = r_inject;
    assign bus.restore     = r_restore;
    assign bus.next_mcause = r_mcause;
    assign bus.next_mepc   = r_mepc;
    assign bus.next_mtval  = r_mtval;
    assign bus.insert_pc   = r_insert;
    assign bus.priv_pc     = r_priv_pc;
endmodule
`default_nettype wire

// File: tb/tb_priv_trap_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_priv_trap_arbiter
// Description : Directed scoreboard bench for priv_trap_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priv_trap_arbiter;
    localparam int          XLEN    = 32;
    localparam int          NUM_INT = 12;
    localparam int          NUM_EXC = 16;
    localparam logic [31:0] NMI_VEC = 32'h0000_0F00;

    typedef struct packed {
        logic        is_ret;
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic [31:0] pc;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
`ifdef PRIV_TRAP_NMI_EN
    logic nmi;
`endif
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    priv_trap_arbiter_if #(.XLEN(XLEN), .NUM_INT(NUM_INT), .NUM_EXC(NUM_EXC)) bus ();

    priv_trap_arbiter #(
        .XLEN(XLEN), .NUM_INT(NUM_INT), .NUM_EXC(NUM_EXC), .NMI_VECTOR(NMI_VEC)
    ) dut (
        .CLK(CLK),
        .RST(RST),
`ifdef PRIV_TRAP_NMI_EN
        .nmi(nmi),
`endif
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_trap(input logic [31:0] mc, input logic [31:0] ep,
                             input logic [31:0] tv, input logic [31:0] pc);
        q.push_back('{is_ret: 1'b0, mcause: mc, mepc: ep, mtval: tv, pc: pc});
    endtask

    task automatic push_ret(input logic [31:0] pc);
        q.push_back('{is_ret: 1'b1, mcause: 32'h0, mepc: 32'h0, mtval: 32'h0, pc: pc});
    endtask

    // Monitor: every redirect strobe must match the oldest expected event.
    always @(negedge CLK) begin
        if (bus.insert_pc === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_redirect: got priv_pc %0h expected no redirect", bus.priv_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("redirect_ctl", {bus.inject, bus.restore, bus.priv_pc},
                    {~e.is_ret, e.is_ret, e.pc});
                if (!e.is_ret)
                    chk("trap_csr", {bus.next_mcause, bus.next_mepc, bus.next_mtval},
                        {e.mcause, e.mepc, e.mtval});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
`ifdef PRIV_TRAP_NMI_EN
        nmi = 1'b0;
`endif
        bus.int_src = '0; bus.int_clr = '0; bus.int_en = '0; bus.glob_ie = 1'b0;
        bus.exc_src = '0; bus.exc_tval = '0; bus.epc = '0; bus.pipe_clear = 1'b0;
        bus.mret = 1'b0; bus.mtvec_base = 32'h100; bus.mtvec_mode = 1'b1; bus.mepc_in = '0;
        step(); step();
        chk("reset_pending", bus.pending, 0);
        chk("reset_flags", {bus.intr, bus.busy, bus.inject, bus.restore, bus.insert_pc}, 0);
        chk("reset_capture", {bus.next_mcause, bus.next_mepc, bus.next_mtval, bus.priv_pc}, 0);
        RST = 1'b0;

        // Vectored interrupt 7
        bus.int_en = 12'h080; bus.glob_ie = 1'b1; bus.pipe_clear = 1'b1;
        bus.epc = 32'h500; bus.exc_tval = 32'hDEAD; bus.int_src = 12'h080;
        push_trap(32'h8000_0007, 32'h500, 32'h0, 32'h11C);
        step(); bus.int_src = '0;
        chk("irq7_pending", bus.pending, 12'h080);
        chk("irq7_intr_idle", bus.intr, 1'b0);
        step();
        chk("irq7_intr_wait", {bus.intr, bus.busy}, 2'b11);
        bus.int_clr = 12'h080;
        step();
        chk("irq7_intr_commit", bus.intr, 1'b0);
        bus.int_clr = '0;
        step(); step();
        chk("irq7_idle", {bus.busy, bus.pending}, 13'h0);

        // Exception 2 beats pending interrupt 11, base PC despite vectored mode
        bus.int_en = 12'h800; bus.int_src = 12'h800;
        step();
        bus.int_src = '0; bus.exc_src = 16'h0024; bus.exc_tval = 32'h1234; bus.epc = 32'h600;
        push_trap(32'h2, 32'h600, 32'h1234, 32'h100);
        step();
        bus.exc_src = '0; bus.int_clr = 12'h800;
        step();
        bus.int_clr = '0;
        step(); step();
        chk("prio_idle", bus.busy, 1'b0);

        // Interrupt 3 upgraded to exception 5 while waiting for drain
        bus.pipe_clear = 1'b0; bus.int_en = 12'h008; bus.int_src = 12'h008; bus.epc = 32'h300;
        step(); bus.int_src = '0;
        step();
        chk("upg_irq_capture", {bus.intr, bus.next_mcause}, {1'b1, 32'h8000_0003});
        bus.int_clr = 12'h008;
        step(); bus.int_clr = '0;
        step();
        bus.exc_src = 16'h0020; bus.epc = 32'h40; bus.exc_tval = 32'h77;
        step();
        chk("upg_exc_capture", {bus.intr, bus.next_mcause}, {1'b1, 32'h5});
        bus.exc_src = '0; bus.pipe_clear = 1'b1;
        push_trap(32'h5, 32'h40, 32'h77, 32'h100);
        step(); step();

        // mret alone, then mret with a simultaneous exception
        bus.mret = 1'b1; bus.mepc_in = 32'h2000;
        push_ret(32'h2000);
        step(); bus.mret = 1'b0;
        chk("mret_busy", bus.busy, 1'b1);
        step();
        bus.mret = 1'b1; bus.exc_src = 16'h0004; bus.epc = 32'h700; bus.exc_tval = 32'h9;
        push_trap(32'h2, 32'h700, 32'h9, 32'h100);
        step(); bus.mret = 1'b0; bus.exc_src = '0;
        step(); step();

        // Direct mode, glob_ie gating, highest index wins
        bus.mtvec_mode = 1'b0; bus.glob_ie = 1'b0; bus.epc = 32'h800;
        bus.int_en = 12'h404; bus.int_src = 12'h404;
        step(); bus.int_src = '0;
        step();
        chk("gated_idle", {bus.busy, bus.pending}, {1'b0, 12'h404});
        bus.glob_ie = 1'b1;
        push_trap(32'h8000_000A, 32'h800, 32'h0, 32'h100);
        push_trap(32'h8000_0002, 32'h800, 32'h0, 32'h100);
        step();
        chk("hi_index_wins", bus.next_mcause, 32'h8000_000A);
        bus.int_clr = 12'h400;
        step(); bus.int_clr = '0;
        step(); step();
        bus.int_clr = 12'h004;
        step(); bus.int_clr = '0;
        step();
        chk("direct_done", bus.pending, 12'h000);

        // Clear beats simultaneous set
        bus.int_en = '0; bus.int_src = 12'h018; bus.int_clr = 12'h008;
        step();
        chk("clr_wins", bus.pending, 12'h010);
        bus.int_src = '0; bus.int_clr = 12'h010;
        step(); bus.int_clr = '0;

        // Reset while waiting aborts the trap
        bus.int_en = 12'h200; bus.pipe_clear = 1'b0; bus.int_src = 12'h200;
        step(); bus.int_src = '0;
        step();
        chk("abort_wait", bus.intr, 1'b1);
        RST = 1'b1;
        step();
        chk("abort_reset", {bus.intr, bus.busy, bus.pending}, 14'h0);
        RST = 1'b0; bus.pipe_clear = 1'b1;
        step(); step(); step(); step();
        chk("abort_no_trap", bus.busy, 1'b0);

`ifdef PRIV_TRAP_NMI_EN
        // NMI overrides a waiting interrupt-11 capture
        bus.mtvec_mode = 1'b1; bus.pipe_clear = 1'b0; bus.epc = 32'h900;
        bus.int_en = 12'h800; bus.int_src = 12'h800;
        step(); bus.int_src = '0;
        step(); bus.int_clr = 12'h800; nmi = 1'b1;
        step(); bus.int_clr = '0; bus.pipe_clear = 1'b1;
        push_trap(32'h8000_0000, 32'h900, 32'h0, NMI_VEC);
        step(); nmi = 1'b0;
        step(); step(); step();
        chk("nmi_done", bus.busy, 1'b0);
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/priv_trap_arbiter.md
Name: priv_trap_arbiter

Overview:
- Parametrised successor to the fixed-source interrupt/exception handler in the privilege block.
- Latches NUM_INT interrupt sources into a pending vector and prioritises them against NUM_EXC exception sources.
- Runs a trap FSM that waits for the pipeline to drain, then strobes CSR updates and a redirect PC.
- Sits between the pipeline hazard unit, the CSR file and pipe control. Supports mtvec direct/vectored modes and mret return.

Parameters:
XLEN, 32, data/PC width
NUM_INT, 12, interrupt sources; bit i maps to interrupt cause i
NUM_EXC, 16, exception sources; bit i maps to exception cause i
NMI_VECTOR, 32'h0000_0000, NMI redirect target (used only with the optional feature)

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-high
int_src  in  NUM_INT  level interrupt requests
int_clr  in  NUM_INT  clear pending bit i
int_en  in  NUM_INT  per-source enable (mie)
glob_ie  in  1  mstatus.MIE
exc_src  in  NUM_EXC  exception flags for the instruction at epc
exc_tval  in  XLEN  faulting value
epc  in  XLEN  PC of the excepting/interrupted instruction
pipe_clear  in  1  pipeline drained
mret  in  1  mret retiring
mtvec_base  in  XLEN  trap base, low 2 bits ignored
mtvec_mode  in  1  0=direct, 1=vectored
mepc_in  in  XLEN  current mepc
pending  out  NUM_INT  mip image
intr  out  1  trap requested; pipeline must flush
busy  out  1  FSM not IDLE
inject  out  1  1-cycle CSR write strobe
restore  out  1  1-cycle mstatus restore strobe (mret)
next_mcause  out  XLEN  bit XLEN-1 = interrupt flag, low bits = cause
next_mepc  out  XLEN  captured epc
next_mtval  out  XLEN  captured tval; 0 for interrupts
insert_pc  out  1  redirect strobe
priv_pc  out  XLEN  redirect target

Behaviour:
- Reset: all outputs 0, pending=0, FSM=IDLE, capture registers 0. RST asserted mid-trap aborts the trap; no inject is issued.
- Pending update: pending[i] <= (pending[i] | int_src[i]) & ~int_clr[i]. Clear wins over a simultaneous set.
- Eligible interrupts: pending & int_en, gated by glob_ie. The highest eligible index wins.
- Exceptions: the lowest set exc_src index wins. Any exception beats any interrupt.
- FSM states: IDLE, WAIT, COMMIT, RET.
- IDLE:
  - On any exc_src: capture cause, exc_tval and epc; go to WAIT.
  - Else on an eligible interrupt: capture cause, tval=0 and epc; go to WAIT.
  - Else on mret: go to RET.
  - Exception/interrupt beats mret in the same cycle.
- WAIT:
  - intr=1 and busy=1.
  - If the capture is an interrupt and exc_src becomes nonzero, re-capture as that exception (upgrade). Further exceptions are otherwise ignored.
  - Deasserting the interrupt source or its enable does not cancel a captured trap.
  - pipe_clear=1 moves to COMMIT on the next edge. pipe_clear already 1 on WAIT entry gives one WAIT cycle.
- COMMIT (1 cycle): inject=1 and insert_pc=1; next_mcause, next_mepc and next_mtval hold the captured values; then return to IDLE.
- priv_pc in COMMIT:
  - Direct mode, or any exception: base.
  - Vectored mode with an interrupt: base + (cause<<2), truncated to XLEN.
- RET (1 cycle): restore=1, insert_pc=1, priv_pc=mepc_in; then IDLE.
- Latency: trap detect to insert_pc = 2 cycles minimum (IDLE→WAIT→COMMIT). mret to insert_pc = 1 cycle.
- Outputs are registered. intr, inject, restore and insert_pc are 0 outside their states.

Optional Feature:
- PRIV_TRAP_NMI_EN defined:
  - Adds input port nmi (1 bit). A rising edge sets nmi_pend.
  - nmi_pend beats every exception and interrupt and ignores glob_ie.
  - In WAIT it also overrides a captured interrupt.
  - At commit: next_mcause = {1'b1, 0}, priv_pc = NMI_VECTOR; nmi_pend clears in COMMIT.
- Undefined: no nmi port; behaviour exactly as above.

Test Plan:
- Interrupt path: int_en[7]=1, glob_ie=1, int_src[7] pulse 1 cycle, pipe_clear=1, mtvec_base=32'h100, mode=1 → pending[7]=1 next cycle. intr for 1 cycle, then inject with next_mcause=32'h8000_0007, priv_pc=32'h11C, next_mtval=0.
- Priority: exc_src=16'h0024 and pending[11] eligible in the same cycle → next_mcause=2, priv_pc=32'h100 even with mode=1.
- Upgrade in WAIT: interrupt 3 captured, pipe_clear=0 for 3 cycles, exc_src[5] arrives with epc=32'h40 → COMMIT with next_mcause=5, next_mepc=32'h40.
- mret: mret=1, mepc_in=32'h2000 in IDLE → next cycle restore=1, insert_pc=1, priv_pc=32'h2000. With exc_src[2] in the same cycle, the trap is taken instead.
- Clear vs set: int_src[3]=1 and int_clr[3]=1 together → pending[3]=0. RST asserted in WAIT → intr=0 next cycle, no inject ever.
- With PRIV_TRAP_NMI_EN: nmi rises while an interrupt-11 capture is waiting → mcause=32'h8000_0000, priv_pc=NMI_VECTOR.
